dp_mem_port: RTL and testbench
==============================

// Module: dp_mem_port
// PURPOSE
//  Memory-side consumer of the dynamic pointer. Performs one data-memory read or write per
//  command, at the address currently held in the pointer register. Drives a req/ack memory bus.
//  Returns a one-shot response to the control unit and, on request, pulses inc_dp back to the
//  pointer for post-increment addressing. Sits between the control unit, the dynamic pointer
//  and the data memory.
// PARAMETERS
//  DATA_W    16   memory data width
//  ADDR_W    16   memory address width; matches the pointer width
//  TIMEOUT   255  max cycles mem_req is held without mem_ack; 0 = wait forever
//  TO_W      8    timeout counter width; must satisfy TIMEOUT < 2**TO_W
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  cmd_valid  in   1       control unit presents a command
//  cmd_ready  out  1       block idle; command accepted when cmd_valid & cmd_ready
//  cmd_write  in   1       1 = write, 0 = read
//  cmd_inc    in   1       post-increment pointer after a successful access
//  cmd_wdata  in   DATA_W  write data
//  dp_addr    in   ADDR_W  current pointer value (pointer data output)
//  inc_dp     out  1       one-cycle increment pulse to the pointer
//  mem_req    out  1       memory request, held until ack or timeout
//  mem_we     out  1       memory write enable; qualified by mem_req
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_ack    in   1       memory completion; read data valid in the same cycle
//  mem_rdata  in   DATA_W  memory read data
//  rsp_valid  out  1       one-cycle response strobe
//  rsp_data   out  DATA_W  read data; 0 for writes and errors
//  rsp_err    out  1       access timed out; qualified by rsp_valid
// BEHAVIOUR
//  FSM states: IDLE -> REQ -> RESP -> IDLE. cmd_ready = (state == IDLE), decoded combinationally
//    from state. All other outputs are registered.
//  Reset values: state IDLE (so cmd_ready = 1); every registered output, including the timeout
//    counter, is 0.
//  IDLE, on accept: capture dp_addr, cmd_write, cmd_wdata and cmd_inc; go to REQ. mem_req rises on
//    the next cycle, with mem_addr, mem_we and mem_wdata stable for the whole of REQ.
//  REQ: mem_ack sampled high -> latch rsp_data (mem_rdata for reads, 0 for writes), drop mem_req,
//    go to RESP. Otherwise the counter increments each cycle. When TIMEOUT != 0 and the count
//    reaches TIMEOUT, drop mem_req, set err and go to RESP.
//  Simultaneous ack and timeout expiry: the ack wins and no error is flagged.
//  RESP: rsp_valid = 1 for exactly one cycle. inc_dp = 1 in the same cycle iff cmd_inc & !err.
//    Then go to IDLE.
//  Latency: accept at cycle 0; mem_req high at cycle 1; ack at cycle k >= 1; rsp_valid at k+1;
//    cmd_ready at k+2. Minimum 3 cycles per access; no pipelining.
//  The pointer updates on the edge after inc_dp, so a command accepted at k+2 captures the
//    incremented address.
//  mem_ack outside REQ is ignored. cmd_valid outside IDLE is ignored; it must be held by the
//    issuer until accepted.
//  Address wrap (0xFFFF -> 0x0000) is done by the pointer; this block does no address arithmetic.
//  Reset mid-operation abandons the access: no rsp_valid, no inc_dp, mem_req low on the next cycle.
//    A late mem_ack is ignored.
// CONFIGURATION
//  DP_AUTOINC_EN defined:     inc_dp behaves as above.
//  DP_AUTOINC_EN not defined: inc_dp tied 0 and cmd_inc ignored. The port stays in the module so
//    the top level is unchanged.
// TESTING
//  1. Read. dp_addr=0x1234, read with inc=1, ack 2 cycles after mem_req with rdata=0xBEEF
//     -> mem_addr=0x1234, mem_we=0, rsp_data=0xBEEF, rsp_valid and inc_dp each 1 cycle, together.
//  2. Write. wdata=0xA5A5, inc=0, ack in the first REQ cycle
//     -> mem_we=1, mem_wdata=0xA5A5, rsp_data=0, rsp_err=0, inc_dp never asserted.
//  3. Timeout. TIMEOUT=8, no ack -> mem_req high exactly 8 cycles, then rsp_valid=1, rsp_err=1,
//     rsp_data=0, inc_dp=0.
//  4. Wrap. Wired to the pointer loaded with 0xFFFF; two read+inc commands back-to-back
//     -> mem_addr 0xFFFF then 0x0000; second accepted on the first cycle cmd_ready returns.
//  5. Reset. Reset asserted during REQ, ack 1 cycle after reset
//     -> all outputs 0 and cmd_ready=1 after the reset edge, no response, ack ignored.
//  6. Macro off. DP_AUTOINC_EN undefined, read with inc=1 -> normal response, inc_dp stays 0.

Source files
------------

// File: rtl/dp_mem_port.sv
// Memory-side consumer of the dynamic pointer: one req/ack access per command, with an optional post-increment.
// Define DP_AUTOINC_EN to enable the inc_dp pulse; otherwise inc_dp is tied low and cmd_inc is ignored.
module dp_mem_port #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_inc,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [ADDR_W-1:0] dp_addr,
  output logic              inc_dp,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              inc_pend_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_err_reg;
  logic              inc_dp_reg;
  logic              expire;

  // Expiry fires in the last allowed REQ cycle, so mem_req is high exactly TIMEOUT cycles.
  assign expire = (TIMEOUT != 0) && (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      to_cnt_reg    <= '0;
      inc_pend_reg  <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      inc_dp_reg    <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      inc_dp_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            mem_addr_reg  <= dp_addr;
            mem_we_reg    <= cmd_write;
            mem_wdata_reg <= cmd_wdata;
`ifdef DP_AUTOINC_EN
            inc_pend_reg  <= cmd_inc;
`else
            inc_pend_reg  <= 1'b0;
`endif
            mem_req_reg   <= 1'b1;
            to_cnt_reg    <= '0;
            state_reg     <= REQ;
          end
        end
        REQ: begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (mem_ack) begin
            rsp_data_reg  <= mem_we_reg ? '0 : mem_rdata;
            rsp_err_reg   <= 1'b0;
            inc_dp_reg    <= inc_pend_reg;
            rsp_valid_reg <= 1'b1;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            state_reg     <= RESP;
          end else if (expire) begin
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b1;
            inc_dp_reg    <= 1'b0;
            rsp_valid_reg <= 1'b1;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            state_reg     <= RESP;
          end else begin
            to_cnt_reg    <= to_cnt_reg + 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

`ifdef DP_AUTOINC_EN
  assign inc_dp = inc_dp_reg;
`else
  // Pulse logic is kept but never reaches the port; the sink keeps the unused inputs tidy.
  logic unused_inc;
  assign unused_inc = cmd_inc ^ inc_dp_reg ^ inc_pend_reg;
  assign inc_dp     = 1'b0;
`endif

endmodule

// File: tb/tb_dp_mem_port.sv
// Randomized bench for dp_mem_port: the bench plays control unit, pointer and memory,
// and predicts every response from the access rules (address, data, error, post-increment).
module tb_dp_mem_port;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 8;
`ifdef DP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic          cmd_inc = 1'b0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [AW-1:0] dp_addr;
  logic          inc_dp;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  // Pointer stand-in: loadable, post-increments (with natural wrap) on inc_dp.
  logic [AW-1:0] ptr = '0;
  logic          ptr_load = 1'b0;
  logic [AW-1:0] ptr_load_val = '0;
  always @(posedge clk) begin
    if (ptr_load) ptr <= ptr_load_val;
    else if (inc_dp) ptr <= ptr + 1'b1;
  end
  assign dp_addr = ptr;

  always #5 clk = ~clk;

  dp_mem_port #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_inc(cmd_inc), .cmd_wdata(cmd_wdata), .dp_addr(dp_addr), .inc_dp(inc_dp),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  int tests = 0;
  int fails = 0;
  int txn = 0;

  // Reference state: where the pointer must be, plus what the last access looked like.
  logic [AW-1:0] exp_ptr = '0;
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_rsp;
  logic          seen_err;
  logic          seen_inc;
  int            seen_req_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (txn %0d, t=%0t)", name, act, exp, txn, $time);
    end
  endtask

  task automatic load_ptr(input logic [AW-1:0] val);
    ptr_load = 1'b1;
    ptr_load_val = val;
    exp_ptr = val;
    @(negedge clk);
    ptr_load = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      mem_ack = 1'($urandom);
      mem_rdata = DW'($urandom);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_req", mem_req, 0);
      chk("idle_rsp", rsp_valid, 0);
      chk("idle_inc", inc_dp, 0);
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  // Called at a negedge with the DUT idle. dly = REQ cycles before ack (0 = first), -1 = never.
  task automatic do_cmd(input bit wr, input bit inc, input logic [DW-1:0] wd,
                        input int dly, input logic [DW-1:0] rd);
    logic [DW-1:0] exp_data;
    bit exp_err;
    bit exp_inc;
    bit acked;
    txn++;
    exp_err  = (dly < 0);
    exp_data = (wr || exp_err) ? '0 : rd;
    exp_inc  = AUTOINC && inc && !exp_err;
    seen_req_cycles = 0;
    chk("accept_ready", cmd_ready, 1);
    chk("accept_req", mem_req, 0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_inc = inc; cmd_wdata = wd; mem_ack = 1'b0;
    @(negedge clk);
    acked = 1'b0;
    for (int c = 1; c <= TO && !acked; c++) begin
      chk("req_high", mem_req, 1);
      chk("busy_ready", cmd_ready, 0);
      chk("req_addr", mem_addr, exp_ptr);
      chk("req_we", mem_we, wr);
      if (wr) chk("req_wdata", mem_wdata, wd);
      chk("req_rsp", rsp_valid, 0);
      chk("req_inc", inc_dp, 0);
      if (c == 1) seen_addr = mem_addr;
      if (mem_req) seen_req_cycles++;
      // Command inputs are noise while busy and must not be picked up.
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
      cmd_inc = 1'($urandom); cmd_wdata = DW'($urandom);
      acked = (c - 1 == dly);
      mem_ack = acked;
      mem_rdata = acked ? rd : DW'($urandom);
      @(negedge clk);
    end
    mem_ack = 1'($urandom);
    mem_rdata = DW'($urandom);
    chk("resp_req", mem_req, 0);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, exp_data);
    chk("resp_err", rsp_err, exp_err);
    chk("resp_inc", inc_dp, exp_inc);
    chk("resp_ready", cmd_ready, 0);
    seen_rsp = rsp_data; seen_err = rsp_err; seen_inc = inc_dp;
    if (exp_inc) exp_ptr = exp_ptr + 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    cmd_valid = 1'b0;
    chk("after_valid", rsp_valid, 0);
    chk("after_inc", inc_dp, 0);
    chk("after_ready", cmd_ready, 1);
    chk("after_ptr", ptr, exp_ptr);
    $display("[TB] txn %0d %s inc=%0d addr=%h dly=%0d rsp=%h err=%0d inc_dp=%0d",
             txn, wr ? "WR" : "RD", inc, seen_addr, dly, seen_rsp, seen_err, seen_inc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_inc", inc_dp, 0);
    idle_cycles(2);

    // Read with post-increment, ack two cycles after mem_req rises.
    load_ptr(16'h1234);
    do_cmd(1'b0, 1'b1, 16'h0000, 2, 16'hBEEF);
    chk("t1_addr", seen_addr, 16'h1234);
    chk("t1_rdata", seen_rsp, 16'hBEEF);
    chk("t1_inc", seen_inc, AUTOINC);

    // Write acked in the first REQ cycle.
    do_cmd(1'b1, 1'b0, 16'hA5A5, 0, 16'h7777);
    chk("t2_rdata", seen_rsp, 16'h0000);
    chk("t2_inc", seen_inc, 0);

    // Timeout with no ack at all.
    do_cmd(1'b0, 1'b1, 16'h0000, -1, 16'h1111);
    chk("t3_req_cycles", seen_req_cycles, 8);
    chk("t3_err", seen_err, 1);
    chk("t3_inc", seen_inc, 0);

    // Ack in the very cycle the timeout would expire: ack wins.
    do_cmd(1'b0, 1'b0, 16'h0000, TO - 1, 16'h5A5A);
    chk("t3b_err", seen_err, 0);
    chk("t3b_rdata", seen_rsp, 16'h5A5A);

    // Wrap: two back-to-back read+inc commands from 0xFFFF.
    load_ptr(16'hFFFF);
    do_cmd(1'b0, 1'b1, 16'h0000, 1, 16'h0F0F);
    a1 = seen_addr;
    do_cmd(1'b0, 1'b1, 16'h0000, 0, 16'hF0F0);
    chk("t4_first", a1, 16'hFFFF);
    chk("t4_second", seen_addr, AUTOINC ? 16'h0000 : 16'hFFFF);

    // Reset during REQ, ack arriving one cycle after the reset edge.
    txn++;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_inc = 1'b1; cmd_wdata = 16'h3C3C;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t5_req", mem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    chk("t5_ready", cmd_ready, 1);
    chk("t5_req0", mem_req, 0);
    chk("t5_we", mem_we, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_wdata", mem_wdata, 0);
    chk("t5_rsp", rsp_valid, 0);
    chk("t5_data", rsp_data, 0);
    chk("t5_err", rsp_err, 0);
    chk("t5_inc", inc_dp, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("t5_late_rsp", rsp_valid, 0);
    chk("t5_late_req", mem_req, 0);
    chk("t5_late_inc", inc_dp, 0);
    chk("t5_ptr", ptr, exp_ptr);
    $display("[TB] txn %0d reset during REQ, late ack ignored", txn);

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      int dly;
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) dly = -1;
      else if (r == 1) dly = TO - 1;
      else dly = int'($urandom_range(0, TO - 2));
      if ($urandom_range(0, 9) == 0) load_ptr(AW'($urandom_range(0, 3)) + 16'hFFFD);
      do_cmd(1'($urandom), 1'($urandom), DW'($urandom), dly, DW'($urandom));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
